// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use, branch redirect, memory wait and mul/div stalls.
// Stall/flush/md_go are combinational same-cycle; state and counters update on clk.
module hazard_ctrl #(
  parameter int CNT_W  = 16,
  parameter int MD_MAX = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_md_valid,
  input  logic             md_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             md_go,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             flush_memwb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             md_timeout
);

  localparam int MDC_W = $clog2(MD_MAX + 1);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t           state, state_nxt;
  logic [MDC_W-1:0] md_cnt, md_cnt_nxt;
  logic             mem_stall, lu, md_hold, timeout_set;

  assign mem_stall = mem_req & ~mem_ready;
  assign lu = ex_mem_read & (ex_rd != 5'd0) &
              ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  // MD_BUSY keeps the pipeline frozen until the result arrives or the budget runs out.
  assign md_hold = (state == MD_BUSY) & ~md_done & (md_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    md_cnt_nxt  = md_cnt;
    timeout_set = 1'b0;
    if (!mem_stall) begin
      case (state)
        RUN: begin
          if (ex_md_valid) begin
            state_nxt  = MD_BUSY;
            md_cnt_nxt = MDC_W'(MD_MAX - 1);
          end
        end
        MD_BUSY: begin
          if (md_done) begin
            state_nxt = RUN;
          end else if (md_cnt == '0) begin
            state_nxt   = RUN;
            timeout_set = 1'b1;
          end else begin
            md_cnt_nxt = md_cnt - 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    md_go       = 1'b0;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    if (rst) begin
      if (mem_stall) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
        flush_memwb = 1'b1;
      end else if (md_hold) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        flush_exmem = 1'b1;
      end else if (state == RUN && ex_md_valid) begin
        md_go       = 1'b1;
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        flush_exmem = 1'b1;
      end else if (ex_branch_taken) begin
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
      end else if (lu) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        flush_idex  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      md_timeout <= 1'b0;
    end else begin
      if (stall_pc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (timeout_set)
        md_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MD_MAX=4, CNT_W=4 so timeout and saturation are reachable).
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  // {md_go, stall pc/ifid/idex/exmem, flush ifid/idex/exmem/memwb}
  localparam logic [8:0] NONE = 9'b0_0000_0000;
  localparam logic [8:0] MEMS = 9'b0_1111_0001;
  localparam logic [8:0] MDB  = 9'b0_1110_0010;
  localparam logic [8:0] MDGO = 9'b1_1110_0010;
  localparam logic [8:0] BR   = 9'b0_0000_1100;
  localparam logic [8:0] LU   = 9'b0_1100_0100;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken, ex_md_valid;
  logic md_done, mem_req, mem_ready;
  logic md_go, stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic [CNT_W-1:0] stall_cnt;
  logic md_timeout;
  logic [8:0] outs;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  assign outs = {md_go, stall_pc, stall_ifid, stall_idex, stall_exmem,
                 flush_ifid, flush_idex, flush_exmem, flush_memwb};

  hazard_ctrl #(.CNT_W(CNT_W), .MD_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_md_valid(ex_md_valid), .md_done(md_done), .mem_req(mem_req), .mem_ready(mem_ready),
    .md_go(md_go), .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .flush_memwb(flush_memwb),
    .stall_cnt(stall_cnt), .md_timeout(md_timeout)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0; ex_rd = 0;
    ex_mem_read = 0; ex_branch_taken = 0; ex_md_valid = 0;
    md_done = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1);
    ex_mem_read = 1; ex_rd = rd; id_rs1 = rs1; id_rs1_used = u1;
  endtask

  // sample outputs at the falling edge, then let the rising edge commit
  task automatic cyc(input string tag, input logic [8:0] exp);
    @(negedge clk);
    chk(tag, {7'd0, outs}, {7'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 0;
    mem_req = 1; mem_ready = 0; ex_md_valid = 1; ex_branch_taken = 1;
    @(negedge clk);
    chk("reset_outs", {7'd0, outs}, {7'd0, NONE});
    chk("reset_cnt", {12'd0, stall_cnt}, 16'd0);
    chk("reset_timeout", {15'd0, md_timeout}, 16'd0);
    @(posedge clk); #1;
    idle();
    rst = 1;

    // load-use: single bubble
    load_use(5'd5, 5'd5, 1'b1);
    cyc("lu_rs1", LU);
    idle();
    cyc("lu_after", NONE);
    chk("lu_cnt", {12'd0, stall_cnt}, 16'd1);
    load_use(5'd0, 5'd0, 1'b1);
    cyc("lu_rd0", NONE);
    load_use(5'd5, 5'd5, 1'b0);
    cyc("lu_unused", NONE);
    idle();
    ex_mem_read = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1;
    cyc("lu_rs2", LU);
    idle();

    // taken branch overrides load-use
    load_use(5'd5, 5'd5, 1'b1);
    ex_branch_taken = 1;
    cyc("branch_over_lu", BR);
    idle();
    chk("branch_cnt", {12'd0, stall_cnt}, 16'd2);

    // mul/div, done three cycles after go
    ex_md_valid = 1;
    cyc("md_go", MDGO);
    cyc("md_busy1", MDB);
    cyc("md_busy2", MDB);
    md_done = 1;
    cyc("md_release", NONE);
    ex_md_valid = 0;
    cyc("md_run", NONE);
    chk("md_cnt", {12'd0, stall_cnt}, 16'd5);
    md_done = 0;

    // memory wait overlapping md_done
    ex_md_valid = 1;
    cyc("mw_go", MDGO);
    ex_md_valid = 0;
    cyc("mw_busy", MDB);
    md_done = 1; mem_req = 1; mem_ready = 0;
    cyc("mw_wait1", MEMS);
    cyc("mw_wait2", MEMS);
    mem_ready = 1;
    cyc("mw_exit", NONE);
    idle();
    cyc("mw_in_run", NONE);
    chk("mw_cnt", {12'd0, stall_cnt}, 16'd9);
    chk("mw_no_timeout", {15'd0, md_timeout}, 16'd0);

    // md_go deferred by a memory wait, then timeout after 4 busy cycles
    ex_md_valid = 1; mem_req = 1; mem_ready = 0;
    cyc("defer_go", MEMS);
    mem_ready = 1;
    cyc("late_go", MDGO);
    idle();
    cyc("to_busy1", MDB);
    cyc("to_busy2", MDB);
    cyc("to_busy3", MDB);
    @(negedge clk);
    chk("to_pre_flag", {15'd0, md_timeout}, 16'd0);
    cyc("to_expire", NONE);
    chk("to_flag", {15'd0, md_timeout}, 16'd1);
    cyc("to_in_run", NONE);
    chk("to_cnt", {12'd0, stall_cnt}, 16'd14);

    // saturation at all-ones
    mem_req = 1; mem_ready = 0;
    cyc("sat_1", MEMS);
    chk("sat_cnt1", {12'd0, stall_cnt}, 16'd15);
    cyc("sat_2", MEMS);
    cyc("sat_3", MEMS);
    chk("sat_cnt3", {12'd0, stall_cnt}, 16'd15);
    idle();

    // reset in the middle of a mul/div stall
    ex_md_valid = 1;
    cyc("rs_go", MDGO);
    ex_md_valid = 0;
    @(negedge clk);
    chk("rs_busy", {7'd0, outs}, {7'd0, MDB});
    #2 rst = 0;
    #1;
    chk("rs_outs", {7'd0, outs}, {7'd0, NONE});
    chk("rs_cnt", {12'd0, stall_cnt}, 16'd0);
    chk("rs_timeout", {15'd0, md_timeout}, 16'd0);
    @(posedge clk); #1;
    rst = 1;
    cyc("rs_abandoned", NONE);
    ex_md_valid = 1;
    cyc("rs_new_go", MDGO);
    idle();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
